muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >=8).
REQ-002 SHALL have parameter MUL_LAT, default 3, multiply latency in cycles (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept; equals !busy.
REQ-007 SHALL have port op  input  4  operation code (muldiv_pkg::md_op_e).
REQ-008 SHALL have port src_a  input  WIDTH  rs operand.
REQ-009 SHALL have port src_b  input  WIDTH  rt operand.
REQ-010 SHALL have port flush  input  1  pipeline flush; cancels work.
REQ-011 SHALL have ports hi and lo  output  WIDTH each  architectural HI/LO registers.
REQ-012 SHALL have port busy  output  1  operation in flight.
REQ-013 SHALL have port done  output  1  one-cycle pulse on HI/LO update by MUL/DIV/MADD/MSUB.

Function
REQ-014 SHALL accept a request on an edge where req_valid && req_ready && !flush; otherwise ignore it.
REQ-015 SHALL implement ops: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI, MTLO.
REQ-016 MTHI/MTLO SHALL write src_a into hi/lo at the accept edge, leave busy 0, and not pulse done.
REQ-017 MULT/MULTU SHALL write the 2*WIDTH product (signed/unsigned) as {hi,lo} exactly MUL_LAT edges after accept.
REQ-018 MADD(U)/MSUB(U) SHALL write {hi,lo} +/- product, modulo 2^(2*WIDTH), sampling {hi,lo} at accept; latency MUL_LAT+1.
REQ-019 DIV/DIVU SHALL write lo=quotient, hi=remainder exactly WIDTH+1 edges after accept (radix-2, one bit per cycle, one fix-up cycle).
REQ-020 Signed division SHALL truncate toward zero; remainder takes the dividend's sign.
REQ-021 Divide by zero SHALL give lo=all ones, hi=src_a, same latency.
REQ-022 Signed most-negative / -1 SHALL give lo=most-negative, hi=0.
REQ-023 busy SHALL rise on the edge after accept of a multi-cycle op and fall on the edge writing HI/LO; done SHALL be 1 for the following cycle only.
REQ-024 FSM states SHALL be IDLE, MUL, DIV, FIX; IDLE->MUL (multiply ops), IDLE->DIV (divide ops), DIV->FIX after WIDTH iterations, MUL/FIX->IDLE on write.
REQ-025 flush=1 SHALL return the FSM to IDLE on that edge, clear busy, suppress done, and leave hi/lo unchanged.
REQ-026 flush on the same edge as a would-be result write SHALL suppress that write.
REQ-027 hi and lo SHALL change only per REQ-016..REQ-022; never hold intermediate values.

Reset
REQ-028 With resetn=0 at an edge: hi=0, lo=0, busy=0, done=0, FSM=IDLE, counters cleared; reset overrides flush and req_valid.
REQ-029 Reset mid-operation SHALL discard the operation with no HI/LO write.

Structure
REQ-030 muldiv_pkg SHALL hold md_op_e, md_state_e and the iteration-counter width function ($clog2(WIDTH+1)).
REQ-031 Divide datapath SHALL be sub-module div_iter (start, signed flag, operands, quotient/remainder, done); multiply SHALL be a MUL_LAT-stage pipeline inside muldiv_unit.

Verification
REQ-032 MULT a=0xFFFFFFFE(-2), b=3 -> after 3 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
REQ-033 DIV a=-7, b=2 -> after 33 edges lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 hi=0, lo=10, MADDU a=4, b=5 -> after 4 edges hi=0, lo=30; MSUB a=1, b=31 -> lo=0xFFFFFFFF, hi=0xFFFFFFFF.
REQ-036 DIVU started, flush at edge 10 -> busy 0 next cycle, hi/lo unchanged, no done; new MTLO 0x55 accepted next edge -> lo=0x55.
REQ-037 resetn=0 during MULT in flight -> hi=lo=0, busy=0, no done after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM
// states and the width helper for the divide iteration counter.
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_MADD  = 4'd2,
    MD_MADDU = 4'd3,
    MD_MSUB  = 4'd4,
    MD_MSUBU = 4'd5,
    MD_DIV   = 4'd6,
    MD_DIVU  = 4'd7,
    MD_MTHI  = 4'd8,
    MD_MTLO  = 4'd9
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } md_state_e;

  // Bits needed to count 0..width divide iterations.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle on operand magnitudes.
// Sign correction and the divide-by-zero result are applied combinationally
// on the outputs, so they are ready during the caller's fix-up cycle.
// 'done' marks the cycle whose closing edge performs the final iteration.
module div_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             kill,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = cnt_w(WIDTH);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_p1, quo_p1, dsr_p1, dvd_p1;
  logic             neg_q_p1, neg_r_p1, dz_p1;
  logic [WIDTH:0]   shifted, diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign shifted = {rem_p1, quo_p1[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_p1};
  assign done    = run && (cnt == CW'(WIDTH - 1));

  // Iteration control: counts WIDTH cycles after start, abandoned on kill
  always_ff @(posedge clk) begin
    if (!resetn || kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  // Datapath: load magnitudes on start, then shift/subtract one bit per cycle
  always_ff @(posedge clk) begin
    if (start) begin
      rem_p1   <= '0;
      quo_p1   <= mag(dividend, sgn);
      dsr_p1   <= mag(divisor, sgn);
      dvd_p1   <= dividend;
      neg_q_p1 <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_p1 <= sgn && dividend[WIDTH-1];
      dz_p1    <= (divisor == '0);
    end else if (run) begin
      if (!diff[WIDTH]) begin
        rem_p1 <= diff[WIDTH-1:0];
        quo_p1 <= {quo_p1[WIDTH-2:0], 1'b1};
      end else begin
        rem_p1 <= shifted[WIDTH-1:0];
        quo_p1 <= {quo_p1[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = dz_p1 ? '1 : (neg_q_p1 ? (~quo_p1 + 1'b1) : quo_p1);
  assign remainder = dz_p1 ? dvd_p1 : (neg_r_p1 ? (~rem_p1 + 1'b1) : rem_p1);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit. Multiplies run through a MUL_LAT-stage product
// pipeline (plus one accumulate stage for MADD/MSUB); divides run in div_iter.
// A single FSM owns busy/done and is the only writer of HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int PW = 2 * WIDTH;
  localparam int LS = MUL_LAT - 1;

  md_state_e state;
  md_op_e    op_e;
  logic      accept, op_mul, op_div, op_sgn, op_acc, op_sub;

  logic signed [PW-1:0] a_ext, b_ext, prod_full;
  logic [PW-1:0]        prod_p [MUL_LAT];
  logic [MUL_LAT-1:0]   vld_p;
  logic [PW-1:0]        acc_base, sum_pl, mul_res;
  logic                 acc_en, acc_sub, vld_pl;
  logic                 mul_wr, acc_wr;

  logic             div_start, div_last;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign op_e      = md_op_e'(op);
  assign req_ready = !busy;
  assign accept    = req_valid && req_ready && !flush;

  // Decode the operation class and signedness
  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
    op_acc = 1'b0;
    op_sub = 1'b0;
    case (op_e)
      MD_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
      MD_MULTU: op_mul = 1'b1;
      MD_MADD:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; end
      MD_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
      MD_MSUB:  begin op_mul = 1'b1; op_sgn = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      MD_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      MD_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
      MD_DIVU:  op_div = 1'b1;
      default:  ;
    endcase
  end

  // Extending to full product width makes the low 2*WIDTH bits exact for both signednesses.
  assign a_ext     = {{WIDTH{op_sgn & src_a[WIDTH-1]}}, src_a};
  assign b_ext     = {{WIDTH{op_sgn & src_b[WIDTH-1]}}, src_b};
  assign prod_full = a_ext * b_ext;

  // Product pipeline: stage 0 captures at accept, then one stage per cycle; accumulate after the last
  always_ff @(posedge clk) begin
    prod_p[0] <= prod_full;
    for (int k = 1; k < MUL_LAT; k++) prod_p[k] <= prod_p[k-1];
    sum_pl <= acc_sub ? (acc_base - prod_p[LS]) : (acc_base + prod_p[LS]);
    if (accept) begin
      acc_base <= {hi, lo};
      acc_en   <= op_acc;
      acc_sub  <= op_sub;
    end
  end

  // Valid chain alongside the product; flush or reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      vld_p  <= '0;
      vld_pl <= 1'b0;
    end else begin
      vld_p[0] <= accept && op_mul;
      for (int k = 1; k < MUL_LAT; k++) vld_p[k] <= vld_p[k-1];
      vld_pl <= vld_p[LS] && acc_en;
    end
  end

  assign mul_wr  = vld_p[LS] && !acc_en;
  assign acc_wr  = vld_pl;
  assign mul_res = acc_wr ? sum_pl : prod_p[LS];

  assign div_start = accept && op_div;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .kill      (flush),
    .sgn       (op_sgn),
    .dividend  (src_a),
    .divisor   (src_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_last)
  );

  // Control FSM: sequences ops, owns busy/done, and is the sole writer of HI/LO
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (accept) begin
            if (op_e == MD_MTHI) hi <= src_a;
            if (op_e == MD_MTLO) lo <= src_a;
            if (op_mul) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end
            if (op_div) begin
              state <= ST_DIV;
              busy  <= 1'b1;
            end
          end
          ST_MUL: if (mul_wr || acc_wr) begin
            {hi, lo} <= mul_res;
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
          ST_DIV: if (div_last) state <= ST_FIX;
          ST_FIX: begin
            hi    <= div_rem;
            lo    <= div_quo;
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors, flush/reset scenarios and
// randomized operations checked against an arithmetic HI/LO model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int ML = 3;

  logic         clk = 1'b0;
  logic         resetn, req_valid, flush;
  logic         req_ready, busy, done;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b, hi, lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] ref_hilo = '0;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi,lo} after an op, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] cur);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        ua, ub, ps, pu, uq, ur;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    ps = sa * sb;
    pu = ua * ub;
    case (o)
      MD_MULT:  return ps;
      MD_MULTU: return pu;
      MD_MADD:  return cur + ps;
      MD_MADDU: return cur + pu;
      MD_MSUB:  return cur - ps;
      MD_MSUBU: return cur - pu;
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      MD_MTHI: return {a, cur[31:0]};
      MD_MTLO: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  task automatic issue(input md_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
    op        = o;
    src_a     = a;
    src_b     = b;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Run one op to completion and compare latency, done pulse and HI/LO with the model.
  task automatic exec(input string tag, input md_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
    int          lat, exp_lat;
    logic [63:0] exp;
    exp = model(o, a, b, ref_hilo);
    if (o == MD_MTHI || o == MD_MTLO)                               exp_lat = 0;
    else if (o == MD_DIV || o == MD_DIVU)                           exp_lat = W + 1;
    else if (o == MD_MULT || o == MD_MULTU)                         exp_lat = ML;
    else                                                            exp_lat = ML + 1;
    issue(o, a, b);
    if (exp_lat == 0) begin
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
    end else begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      lat = 1;
      while (!done && lat < 200) begin
        step();
        lat++;
      end
      check({tag, " lat"}, 64'(lat - 1), 64'(exp_lat));
      step();
      check({tag, " done pulse"}, 64'(done), 64'd0);
    end
    check({tag, " hilo"}, {hi, lo}, exp);
    ref_hilo = exp;
  endtask

  initial begin
    md_op_e       ro;
    logic [W-1:0] ra, rb;
    logic         saw_done;

    // Reset dominates an asserted request and flush
    resetn = 1'b0; flush = 1'b1; req_valid = 1'b1;
    op = MD_MTHI; src_a = '1; src_b = '0;
    repeat (3) step();
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0; flush = 1'b0;
    resetn = 1'b1;
    step();

    exec("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    exec("div", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    exec("divu0", MD_DIVU, 32'd7, 32'd0);
    check("divu0 vec", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    exec("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf vec", {hi, lo}, 64'h0000_0000_8000_0000);

    exec("mthi", MD_MTHI, 32'd0, 32'd0);
    exec("mtlo", MD_MTLO, 32'd10, 32'd0);
    exec("maddu", MD_MADDU, 32'd4, 32'd5);
    check("maddu vec", {hi, lo}, 64'd30);
    exec("msub", MD_MSUB, 32'd1, 32'd31);
    check("msub vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush a divide mid-flight, then a move right after
    exec("mthi2", MD_MTHI, 32'h1234_5678, 32'd0);
    exec("mtlo2", MD_MTLO, 32'h9ABC_DEF0, 32'd0);
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hilo", {hi, lo}, ref_hilo);
    issue(MD_MTLO, 32'h55, 32'd0);
    check("flush mtlo", 64'(lo), 64'h55);
    ref_hilo = {ref_hilo[63:32], 32'h55};
    saw_done = 1'b0;
    repeat (40) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("flush no done", 64'(saw_done), 64'd0);
    check("flush hilo2", {hi, lo}, ref_hilo);

    // Reset while a multiply is in flight
    issue(MD_MULT, 32'd5, 32'd6);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rstmul hilo", {hi, lo}, 64'd0);
    check("rstmul busy", 64'(busy), 64'd0);
    ref_hilo = '0;
    saw_done = 1'b0;
    repeat (6) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("rstmul no done", 64'(saw_done), 64'd0);
    check("rstmul hilo2", {hi, lo}, 64'd0);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ro = md_op_e'($urandom_range(0, 9));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      exec($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
